axi_ram_rd_arbiter: RTL and testbench
=====================================

// Module: axi_ram_rd_arbiter
// PURPOSE
// Round-robin arbiter sharing the single AXI4 read port (AR/R) of the simulation RAM among M_COUNT
// requesters. One burst is in flight at a time. The AR fields are registered toward the RAM. R beats
// route back to the granted requester only. Sits between accelerator/DMA read masters and the RAM
// read port; a beat counter checks that RLAST position matches ARLEN.
// PARAMETERS
// M_COUNT     2   number of requesters, 2..2**M_ID_WIDTH
// DATA_WIDTH  32  R data width, bits
// ADDR_WIDTH  32  byte address width
// M_ID_WIDTH  8   width of m_axi_arid; carries the grant index, zero-extended
// PORTS
// clk              in   1                     clock, all logic on rising edge
// rst              in   1                     synchronous reset, active-low
// s_axi_araddr     in   M_COUNT*ADDR_WIDTH    per-requester byte address; slice k = requester k
// s_axi_arlen      in   M_COUNT*8             per-requester burst length minus 1
// s_axi_arvalid    in   M_COUNT               per-requester address valid
// s_axi_arready    out  M_COUNT               one-hot accept
// s_axi_rdata      out  DATA_WIDTH            shared, = m_axi_rdata
// s_axi_rlast      out  1                     shared, = m_axi_rlast
// s_axi_rvalid     out  M_COUNT               one-hot beat valid, granted requester only
// s_axi_rready     in   M_COUNT               per-requester beat ready
// m_axi_arid       out  M_ID_WIDTH            grant index
// m_axi_araddr     out  ADDR_WIDTH            registered address toward RAM
// m_axi_arlen      out  8                     registered length
// m_axi_arsize     out  3                     constant $clog2(DATA_WIDTH/8)
// m_axi_arburst    out  2                     constant 2'b01 (INCR)
// m_axi_arvalid    out  1                     address valid toward RAM
// m_axi_arready    in   1                     RAM address ready
// m_axi_rdata      in   DATA_WIDTH            RAM read data
// m_axi_rlast      in   1                     RAM last beat
// m_axi_rvalid     in   1                     RAM beat valid
// m_axi_rready     out  1                     = s_axi_rready[grant] in DATA, else 0
// err_rlast        out  1                     1-cycle pulse on RLAST/ARLEN mismatch
// BEHAVIOUR
// - Reset (rst=0 at a clock edge): state=IDLE, last_grant=M_COUNT-1 (requester 0 wins first). All
//   valid/ready outputs and err_rlast are 0. m_axi_ar* data registers are 0. An in-flight burst is
//   abandoned; the RAM shares this reset.
// - FSM IDLE -> ADDR -> DATA -> IDLE.
// - IDLE: grant = first k with s_axi_arvalid[k]=1, scanning from last_grant+1 modulo M_COUNT.
//   s_axi_arready = onehot(grant) combinationally in the same cycle (0 if no request). On that
//   edge: latch grant, araddr[grant], arlen[grant]; go to ADDR.
// - ADDR: m_axi_arvalid=1. All m_axi_ar* held stable until m_axi_arready=1. On handshake:
//   beat_cnt<=arlen; go to DATA.
// - DATA: s_axi_rvalid = onehot(grant) & {M_COUNT{m_axi_rvalid}}; m_axi_rready=s_axi_rready[grant];
//   non-granted rready ignored. Each beat handshake decrements beat_cnt (8-bit, no wrap check needed).
//   A handshake with m_axi_rlast=1 ends the burst: last_grant<=grant, go to IDLE.
// - err_rlast=1 for one cycle on a beat handshake where (rlast=1 && beat_cnt!=0) or
//   (rlast=0 && beat_cnt==0). Only rlast ends a burst; a burst that runs long keeps routing beats.
// - s_axi_arready=0 and m_axi_arvalid=0 outside IDLE/ADDR respectively; waiting requesters hold.
// - Latency: accept at cycle T -> m_axi_arvalid at T+1. Final beat at T -> next accept possible at
//   T+1.
// - Fairness: a continuously requesting master waits at most M_COUNT-1 bursts.
// TESTING
// 1 rst=0 3 cycles with all arvalid=1 -> all arready/rvalid/m_axi_arvalid/err=0; release -> req0 accepted first
// 2 req0 addr 0x40000100 len 3, RAM ready -> m_arid=0, m_araddr=0x40000100, 4 beats on s_rvalid[0], s_rvalid[1]=0
// 3 req0,req1 both valid after reset -> order 0,1; both re-request -> 0 (round-robin), each burst complete
// 4 s_rready[g]=0 for 3 cycles mid-burst -> m_rready=0, rdata held, beat count unchanged, no beat lost
// 5 m_arready held 0 for 5 cycles -> m_arvalid=1 with araddr/arlen/arid stable until handshake
// 6 stub RAM asserts rlast on beat 2 of len 3 -> err_rlast 1 cycle, IDLE next cycle; rst=0 mid-DATA -> IDLE, outputs 0

Source files
------------

// File: rtl/axi_ram_rd_arbiter.sv
// Round-robin arbiter that shares one AXI4 read port (AR/R) among M_COUNT requesters.
// Only one burst is in flight at a time. AR fields toward the RAM are registered.
// R beats route back to the granted requester only.
// A beat counter flags any RLAST that disagrees with the accepted ARLEN.
module axi_ram_rd_arbiter #(
    parameter int unsigned M_COUNT    = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned M_ID_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [M_COUNT*ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [M_COUNT*8-1:0]          s_axi_arlen,
    input  logic [M_COUNT-1:0]            s_axi_arvalid,
    output logic [M_COUNT-1:0]            s_axi_arready,
    output logic [DATA_WIDTH-1:0]         s_axi_rdata,
    output logic                          s_axi_rlast,
    output logic [M_COUNT-1:0]            s_axi_rvalid,
    input  logic [M_COUNT-1:0]            s_axi_rready,

    output logic [M_ID_WIDTH-1:0]         m_axi_arid,
    output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,

    output logic                          err_rlast
);

    localparam int unsigned GW   = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
    localparam int unsigned SIZE = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [GW-1:0]           grant_q;
    logic [GW-1:0]           last_grant_q;
    logic [GW-1:0]           grant_c;
    logic [GW-1:0]           cand_c;
    logic                    req_found_c;
    logic                    accept_c;
    logic                    r_hs_c;
    logic                    rlast_bad_c;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic [7:0]              arlen_q;
    logic [7:0]              beat_cnt_q;
    logic                    err_q;
    int unsigned             idx_c;

    // Round-robin search: first requester after the previous winner, wrapping modulo M_COUNT
    always_comb begin
        grant_c     = last_grant_q;
        req_found_c = 1'b0;
        idx_c       = 0;
        cand_c      = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            idx_c  = (32'(last_grant_q) + 32'(i) + 32'd1) % M_COUNT;
            cand_c = GW'(idx_c);
            if (!req_found_c && s_axi_arvalid[cand_c]) begin
                grant_c     = cand_c;
                req_found_c = 1'b1;
            end
        end
    end

    // A beat transfers only while a burst is in DATA and the granted requester is ready
    assign r_hs_c      = (state_q == DATA) && m_axi_rvalid && s_axi_rready[grant_q];
    // RLAST must coincide exactly with the counter reaching zero
    assign rlast_bad_c = m_axi_rlast ? (beat_cnt_q != 8'd0) : (beat_cnt_q == 8'd0);

    // Next-state and handshake outputs; everything forced quiet while reset is held
    always_comb begin
        state_d       = state_q;
        s_axi_arready = '0;
        m_axi_arvalid = 1'b0;
        s_axi_rvalid  = '0;
        m_axi_rready  = 1'b0;
        accept_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_found_c) begin
                    s_axi_arready = M_COUNT'(1) << grant_c;
                    accept_c      = 1'b1;
                    state_d       = ADDR;
                end
            end
            ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                s_axi_rvalid = (M_COUNT'(1) << grant_q) & {M_COUNT{m_axi_rvalid}};
                m_axi_rready = s_axi_rready[grant_q];
                if (r_hs_c && m_axi_rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst) begin
            state_d       = IDLE;
            s_axi_arready = '0;
            m_axi_arvalid = 1'b0;
            s_axi_rvalid  = '0;
            m_axi_rready  = 1'b0;
            accept_c      = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant, AR payload, beat counter and error pulse registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_q      <= '0;
            last_grant_q <= GW'(M_COUNT - 1);
            araddr_q     <= '0;
            arlen_q      <= '0;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            // Error is reported the cycle after the offending beat
            err_q <= r_hs_c && rlast_bad_c;
            if (accept_c) begin
                grant_q  <= grant_c;
                araddr_q <= s_axi_araddr[grant_c*ADDR_WIDTH +: ADDR_WIDTH];
                arlen_q  <= s_axi_arlen[grant_c*8 +: 8];
            end
            if ((state_q == ADDR) && m_axi_arready) begin
                beat_cnt_q <= arlen_q;
            end
            if (r_hs_c) begin
                beat_cnt_q <= beat_cnt_q - 8'd1;
                if (m_axi_rlast) begin
                    last_grant_q <= grant_q;
                end
            end
        end
    end

    assign m_axi_arid    = M_ID_WIDTH'(grant_q);
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;
    assign s_axi_rdata   = m_axi_rdata;
    assign s_axi_rlast   = m_axi_rlast;
    assign err_rlast     = err_q;

endmodule

// File: tb/tb_axi_ram_rd_arbiter.sv
// Directed bench for axi_ram_rd_arbiter: table of bursts plus hand-written corner sequences.
module tb_axi_ram_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_araddr;
    logic [15:0] s_arlen;
    logic [1:0]  s_arvalid;
    logic [1:0]  s_arready;
    logic [31:0] s_rdata;
    logic        s_rlast;
    logic [1:0]  s_rvalid;
    logic [1:0]  s_rready;
    logic [7:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;
    logic        err_rlast;

    int total = 0;
    int bad   = 0;

    axi_ram_rd_arbiter #(
        .M_COUNT(2), .DATA_WIDTH(32), .ADDR_WIDTH(32), .M_ID_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen), .s_axi_arvalid(s_arvalid),
        .s_axi_arready(s_arready), .s_axi_rdata(s_rdata), .s_axi_rlast(s_rlast),
        .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
        .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
        .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arvalid(m_arvalid),
        .m_axi_arready(m_arready), .m_axi_rdata(m_rdata), .m_axi_rlast(m_rlast),
        .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready), .err_rlast(err_rlast)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mask;
        int          g;
        logic [31:0] addr;
        logic [7:0]  len;
    } vec_t;

    vec_t vt[6];

    function automatic logic [1:0] oh(input int g);
        oh = 2'b01 << g;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE, expect the given grant, take the accept edge
    task automatic accept(input logic [1:0] mask, input int g, input logic [31:0] a, input logic [7:0] l);
        s_araddr[g*32 +: 32] = a;
        s_arlen[g*8 +: 8]    = l;
        s_arvalid            = mask;
        #1;
        chk("arready_grant", s_arready, oh(g));
        step();
        s_arvalid = '0;
    endtask

    // Hold RAM arready low for 'stall' cycles, then complete the AR handshake
    task automatic addr_phase(input int g, input logic [31:0] a, input logic [7:0] l, input int stall);
        for (int k = 0; k <= stall; k++) begin
            m_arready = (k == stall);
            #1;
            if (k == 0) chk("err_quiet", err_rlast, 0);
            chk("m_arvalid", m_arvalid, 1);
            chk("m_arid", m_arid, g);
            chk("m_araddr", m_araddr, a);
            chk("m_arlen", m_arlen, l);
            chk("s_arready_addr", s_arready, 0);
            step();
        end
        m_arready = 1'b0;
    endtask

    // One R beat; granted requester stalls 'stall' cycles while the other one is ready
    task automatic beat(input int g, input logic [31:0] d, input logic last, input int stall, input logic exp_err);
        m_rvalid = 1'b1;
        m_rdata  = d;
        m_rlast  = last;
        for (int k = 0; k <= stall; k++) begin
            s_rready = (k == stall) ? 2'b11 : ~oh(g);
            #1;
            chk("s_rvalid", s_rvalid, oh(g));
            chk("m_rready", m_rready, (k == stall));
            chk("s_rdata", s_rdata, d);
            chk("s_rlast", s_rlast, last);
            step();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = '0;
        #1;
        chk("err_rlast", err_rlast, exp_err);
    endtask

    task automatic burst(input int g, input logic [31:0] a, input logic [7:0] l);
        for (int i = 0; i <= int'(l); i++) begin
            beat(g, a + 32'(4 * i), (i == int'(l)), 0, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{mask: 2'b11, g: 0, addr: 32'h4000_0100, len: 8'd3};
        vt[1] = '{mask: 2'b11, g: 1, addr: 32'h2000_0040, len: 8'd1};
        vt[2] = '{mask: 2'b11, g: 0, addr: 32'h4000_0200, len: 8'd0};
        vt[3] = '{mask: 2'b10, g: 1, addr: 32'h2000_0080, len: 8'd2};
        vt[4] = '{mask: 2'b10, g: 1, addr: 32'h2000_0100, len: 8'd0};
        vt[5] = '{mask: 2'b01, g: 0, addr: 32'h4000_0300, len: 8'd1};

        s_araddr  = '0;
        s_arlen   = '0;
        s_arvalid = 2'b11;
        s_rready  = 2'b11;
        m_arready = 1'b1;
        m_rdata   = 32'hdead_beef;
        m_rlast   = 1'b0;
        m_rvalid  = 1'b1;
        rst       = 1'b0;

        // Reset held three cycles with every request pending
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_arready", s_arready, 0);
            chk("rst_s_rvalid", s_rvalid, 0);
            chk("rst_m_arvalid", m_arvalid, 0);
            chk("rst_m_rready", m_rready, 0);
            chk("rst_err", err_rlast, 0);
        end
        chk("rst_m_araddr", m_araddr, 0);
        chk("rst_m_arlen", m_arlen, 0);
        chk("rst_m_arid", m_arid, 0);
        chk("arsize", m_arsize, 2);
        chk("arburst", m_arburst, 1);

        rst       = 1'b1;
        m_rvalid  = 1'b0;
        m_arready = 1'b0;
        s_rready  = '0;
        #1;
        chk("first_grant", s_arready, 2'b01);

        // Table of complete bursts, round-robin order hand-computed
        for (int i = 0; i < 6; i++) begin
            accept(vt[i].mask, vt[i].g, vt[i].addr, vt[i].len);
            addr_phase(vt[i].g, vt[i].addr, vt[i].len, 0);
            burst(vt[i].g, vt[i].addr, vt[i].len);
        end

        // AR stalled 5 cycles, then granted requester withholds rready 3 cycles mid-burst
        accept(2'b11, 1, 32'h3000_0000, 8'd3);
        addr_phase(1, 32'h3000_0000, 8'd3, 5);
        beat(1, 32'h3000_0000, 1'b0, 0, 1'b0);
        beat(1, 32'h3000_0004, 1'b0, 3, 1'b0);
        beat(1, 32'h3000_0008, 1'b0, 0, 1'b0);
        beat(1, 32'h3000_000c, 1'b1, 0, 1'b0);

        // Early RLAST on the third beat of a four-beat burst
        accept(2'b01, 0, 32'h5000_0000, 8'd3);
        addr_phase(0, 32'h5000_0000, 8'd3, 0);
        beat(0, 32'h5000_0000, 1'b0, 0, 1'b0);
        beat(0, 32'h5000_0004, 1'b0, 0, 1'b0);
        beat(0, 32'h5000_0008, 1'b1, 0, 1'b1);

        // Next cycle is IDLE again; single-beat burst that runs one beat long
        accept(2'b10, 1, 32'h6000_0000, 8'd0);
        addr_phase(1, 32'h6000_0000, 8'd0, 0);
        beat(1, 32'h6000_0000, 1'b0, 0, 1'b1);
        s_arvalid = 2'b11;
        #1;
        chk("hold_in_data", s_arready, 0);
        beat(1, 32'h6000_0004, 1'b1, 0, 1'b1);

        // Reset in the middle of a burst
        accept(2'b11, 0, 32'h7000_0000, 8'd3);
        addr_phase(0, 32'h7000_0000, 8'd3, 0);
        beat(0, 32'h7000_0000, 1'b0, 0, 1'b0);
        m_rvalid = 1'b1;
        s_rready = 2'b11;
        rst      = 1'b0;
        #1;
        chk("midrst_s_rvalid", s_rvalid, 0);
        chk("midrst_m_rready", m_rready, 0);
        step();
        rst       = 1'b1;
        s_arvalid = '0;
        #1;
        chk("postrst_m_arvalid", m_arvalid, 0);
        chk("postrst_s_rvalid", s_rvalid, 0);
        chk("postrst_m_rready", m_rready, 0);
        chk("postrst_err", err_rlast, 0);
        chk("postrst_m_araddr", m_araddr, 0);
        m_rvalid = 1'b0;
        s_rready = '0;
        accept(2'b11, 0, 32'h7000_0100, 8'd0);
        addr_phase(0, 32'h7000_0100, 8'd0, 0);
        burst(0, 32'h7000_0100, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
